// File: rtl/operand_sequencer_if.sv
// Nibble-stream input and result-return handshakes of the operand sequencer.
// The sequencer takes the slave side; the feeder/consumer takes the master side.
interface operand_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_mode;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_mode
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_mode
    );
endinterface

// File: rtl/operand_sequencer.sv
// Assembles a header plus five operand nibbles into a parallel bundle for the
// arithmetic unit, waits SETTLE cycles, captures its result and returns it.
module operand_sequencer #(
    parameter logic [1:0] SYNC   = 2'b10,
    parameter int         SETTLE = 1,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_sequencer_if.slave bus,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic [3:0]       c,
    output logic [3:0]       d,
    output logic [3:0]       e,
    output logic [1:0]       mode,
    input  logic [7:0]       y_in,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] idx;
    logic [1:0] settle_cnt;
    logic       in_ready;
    logic       res_valid;
    logic       accept;
    logic [7:0] res_data;
    logic [1:0] res_mode;

    assign accept        = bus.in_valid && in_ready;
    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_mode  = res_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_data[3:2] == SYNC) next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && idx == 3'd4) next_state = EXEC;
            end
            EXEC: begin
                if (settle_cnt == SETTLE_LAST) next_state = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Bundle, capture and counter registers; operands only move on LOAD accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            e          <= '0;
            mode       <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            res_data   <= '0;
            res_mode   <= '0;
            txn_count  <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_data[3:2] == SYNC) begin
                            mode <= bus.in_data[1:0];
                            idx  <= '0;
                        end else begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        case (idx)
                            3'd0:    a <= bus.in_data;
                            3'd1:    b <= bus.in_data;
                            3'd2:    c <= bus.in_data;
                            3'd3:    d <= bus.in_data;
                            default: e <= bus.in_data;
                        endcase
                        idx        <= idx + 3'd1;
                        settle_cnt <= '0;
                    end
                end
                EXEC: begin
                    settle_cnt <= settle_cnt + 2'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        res_data <= y_in;
                        res_mode <= mode;
                    end
                end
                RESP: begin
                    if (bus.res_ready) txn_count <= txn_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed test of operand_sequencer: a SETTLE=1 unit fed by a modelled
// arithmetic unit, and a SETTLE=4 unit with a bench-driven result.
module tb_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] a1, b1, c1, d1, e1, a2, b2, c2, d2, e2;
    logic [1:0] mode1, mode2;
    logic [7:0] y1, y2;
    logic       busy1, busy2;
    logic [7:0] txn1, err1, txn2, err2;
    int         checks;
    int         errors;

    operand_sequencer_if bus1();
    operand_sequencer_if bus2();

    operand_sequencer #(.SYNC(2'b10), .SETTLE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .mode(mode1), .y_in(y1),
        .busy(busy1), .txn_count(txn1), .err_count(err1)
    );

    operand_sequencer #(.SYNC(2'b10), .SETTLE(4), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .mode(mode2), .y_in(y2),
        .busy(busy2), .txn_count(txn2), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the arithmetic unit feeding the SETTLE=1 sequencer.
    always_comb begin
        case (mode1)
            2'd0:    y1 = 8'((({4'b0, a1} + {4'b0, b1}) * ({4'b0, c1} + {4'b0, d1})));
            2'd1:    y1 = 8'(({4'b0, a1} * {4'b0, c1}) + ({4'b0, b1} * {4'b0, d1}));
            2'd2:    y1 = {4'b0, a1} + {4'b0, b1} + {4'b0, c1} + {4'b0, d1} + {4'b0, e1};
            default: y1 = {4'b0, a1 ^ b1 ^ c1 ^ d1 ^ e1};
        endcase
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one nibble and returns at the following negedge.
    task automatic apply_stimulus(input int unit, input logic [3:0] v);
        int k;
        k = 0;
        while (((unit == 1) ? !bus1.in_ready : !bus2.in_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output("in_ready_before_send", (unit == 1) ? bus1.in_ready : bus2.in_ready, 1);
        if (unit == 1) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = v;
        end else begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = v;
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic handshake1;
        bus1.res_ready = 1'b1;
        @(negedge clk);
        bus1.res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        y2 = 8'h00;
        bus1.in_valid = 1'b0; bus1.in_data = 4'h0; bus1.res_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = 4'h0; bus2.res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_a", a1, 0);
        check_output("rst_mode", mode1, 0);
        check_output("rst_res_valid", bus1.res_valid, 0);
        check_output("rst_busy", busy1, 0);
        check_output("rst_counts", {txn1, err1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_in_ready", bus1.in_ready, 1);

        // Mode 0: (1+2)*(3+4) = 0x15
        apply_stimulus(1, 4'h8);
        check_output("t1_busy", busy1, 1);
        apply_stimulus(1, 4'h1);
        apply_stimulus(1, 4'h2);
        apply_stimulus(1, 4'h3);
        apply_stimulus(1, 4'h4);
        apply_stimulus(1, 4'h0);
        check_output("t1_exec_no_valid", bus1.res_valid, 0);
        check_output("t1_exec_in_ready", bus1.in_ready, 0);
        @(negedge clk);
        check_output("t1_res_valid", bus1.res_valid, 1);
        check_output("t1_res_data", bus1.res_data, 8'h15);
        check_output("t1_res_mode", bus1.res_mode, 0);
        handshake1();
        check_output("t1_txn", txn1, 1);
        check_output("t1_idle", busy1, 0);

        // Mode 1 with 2-cycle gaps: 1*3+2*4 = 0x0B
        apply_stimulus(1, 4'h9);
        check_output("t2_mode", mode1, 1);
        apply_stimulus(1, 4'h1);
        repeat (2) @(negedge clk);
        check_output("t2_gap_busy", busy1, 1);
        check_output("t2_gap_a", a1, 1);
        apply_stimulus(1, 4'h2);
        repeat (2) @(negedge clk);
        apply_stimulus(1, 4'h3);
        repeat (2) @(negedge clk);
        apply_stimulus(1, 4'h4);
        repeat (2) @(negedge clk);
        check_output("t2_no_valid_yet", bus1.res_valid, 0);
        apply_stimulus(1, 4'h0);
        check_output("t2_bundle", {a1, b1, c1, d1, e1}, 20'h12340);
        @(negedge clk);
        check_output("t2_res_data", bus1.res_data, 8'h0B);
        check_output("t2_res_mode", bus1.res_mode, 1);
        handshake1();
        check_output("t2_txn", txn1, 2);
        check_output("t2_res_hold", bus1.res_data, 8'h0B);
        check_output("t2_res_valid_low", bus1.res_valid, 0);

        // Bad headers dropped, then a good mode-2 header
        apply_stimulus(1, 4'h4);
        apply_stimulus(1, 4'hF);
        check_output("t3_err", err1, 2);
        check_output("t3_idle", busy1, 0);
        check_output("t3_in_ready", bus1.in_ready, 1);
        check_output("t3_mode_kept", mode1, 1);
        apply_stimulus(1, 4'hA);
        check_output("t3_mode", mode1, 2);

        // Mode 2 sum 5+6+7+8+9 = 0x23, result stalled for 3 cycles
        apply_stimulus(1, 4'h5);
        apply_stimulus(1, 4'h6);
        apply_stimulus(1, 4'h7);
        apply_stimulus(1, 4'h8);
        apply_stimulus(1, 4'h9);
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'h8;
        for (int i = 0; i < 3; i++) begin
            check_output("t4_stall_valid", bus1.res_valid, 1);
            check_output("t4_stall_data", bus1.res_data, 8'h23);
            check_output("t4_stall_in_ready", bus1.in_ready, 0);
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
        check_output("t4_a_kept", a1, 5);
        check_output("t4_err_kept", err1, 2);
        check_output("t4_txn_before", txn1, 2);
        handshake1();
        check_output("t4_txn", txn1, 3);

        // Async reset mid-LOAD, then a fresh transaction: (2+3)*(4+5) = 0x2D
        apply_stimulus(1, 4'h8);
        apply_stimulus(1, 4'h1);
        apply_stimulus(1, 4'h2);
        apply_stimulus(1, 4'h3);
        #2 rst_n = 1'b0;
        #1;
        check_output("t5_a", a1, 0);
        check_output("t5_bundle", {a1, b1, c1, d1, e1, mode1}, 0);
        check_output("t5_busy", busy1, 0);
        check_output("t5_counts", {txn1, err1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(1, 4'h8);
        apply_stimulus(1, 4'h2);
        apply_stimulus(1, 4'h3);
        apply_stimulus(1, 4'h4);
        apply_stimulus(1, 4'h5);
        apply_stimulus(1, 4'h0);
        @(negedge clk);
        check_output("t5_res_data", bus1.res_data, 8'h2D);
        handshake1();
        check_output("t5_txn", txn1, 1);

        // SETTLE=4 unit: only the y_in present in the 4th EXEC cycle is captured
        apply_stimulus(2, 4'hB);
        check_output("t6_mode", mode2, 3);
        for (int i = 0; i < 5; i++) apply_stimulus(2, 4'hF);
        check_output("t6_a", a2, 4'hF);
        y2 = 8'hA1;
        check_output("t6_wait1", bus2.res_valid, 0);
        @(negedge clk);
        y2 = 8'hA2;
        check_output("t6_wait2", bus2.res_valid, 0);
        @(negedge clk);
        y2 = 8'hA3;
        check_output("t6_wait3", bus2.res_valid, 0);
        @(negedge clk);
        y2 = 8'hA4;
        check_output("t6_wait4", bus2.res_valid, 0);
        @(negedge clk);
        check_output("t6_res_valid", bus2.res_valid, 1);
        check_output("t6_res_data", bus2.res_data, 8'hA4);
        check_output("t6_res_mode", bus2.res_mode, 3);
        y2 = 8'hA5;
        @(negedge clk);
        check_output("t6_res_hold", bus2.res_data, 8'hA4);
        bus2.res_ready = 1'b1;
        @(negedge clk);
        bus2.res_ready = 1'b0;
        check_output("t6_txn", txn2, 1);
        check_output("t6_idle", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
